// File: rtl/mdu_divider_pkg.sv
// Shared MDU definitions: op encoding (also used by the multiplier),
// divider state encoding and default datapath width.
package rv_mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Matches funct3[1:0] of the RV32M divide group.
  typedef enum logic [1:0] {
    MDU_DIV  = 2'b00,
    MDU_DIVU = 2'b01,
    MDU_REM  = 2'b10,
    MDU_REMU = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'b00,
    DIV_CALC  = 2'b01,
    DIV_FIXUP = 2'b10,
    DIV_DONE  = 2'b11
  } div_state_t;

  // Signed ops have funct3[0] clear.
  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

  // Remainder ops have funct3[1] set.
  function automatic logic op_is_rem(input mdu_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_divider_if.sv
// Request/response bundle between the EX stage and the divider.
interface mdu_divider_if
  import rv_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            start;
  mdu_op_t         op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  modport master (
    output start, op, dividend, divisor, flush,
    input  result, busy, done
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output result, busy, done
  );

endinterface

// File: rtl/mdu_divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and keep the trial difference when it is non-negative.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Trial subtract at XLEN+1 bits so divisors with the MSB set are handled.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a
// single-cycle path for divide-by-zero and signed overflow.
//
// state     | meaning
// ----------+-------------------------------------------------------
// DIV_IDLE  | waiting for start; busy=0, done=0
// DIV_CALC  | one quotient bit per cycle, XLEN cycles; busy=1
// DIV_FIXUP | sign correction and quotient/remainder select; busy=1
// DIV_DONE  | result valid, done=1 for one cycle; start accepted here
module mdu_divider
  import rv_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic           clk,
  input logic           reset_n,
  mdu_divider_if.slave  bus
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q;
  mdu_op_t         op_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvsr_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            busy_q;
  logic            done_q;

  logic            sgn_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] fast_res;

  logic [XLEN-1:0] step_rem;
  logic            step_q;

  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fix_res;

  // Operand conditioning and special-case detection on the incoming request.
  always_comb begin
    sgn_in   = op_is_signed(bus.op);
    a_neg    = sgn_in & bus.dividend[XLEN-1];
    b_neg    = sgn_in & bus.divisor[XLEN-1];
    a_abs    = a_neg ? -bus.dividend : bus.dividend;
    b_abs    = b_neg ? -bus.divisor  : bus.divisor;
    div_zero = (bus.divisor == '0);
    sgn_ovf  = sgn_in & (bus.dividend == INT_MIN) & (bus.divisor == '1);
    if (div_zero) begin
      fast_res = op_is_rem(bus.op) ? bus.dividend : '1;
    end else begin
      fast_res = op_is_rem(bus.op) ? '0 : INT_MIN;
    end
  end

  mdu_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_in      (rem_q),
    .divisor     (dvsr_q),
    .dividend_bit(quo_q[XLEN-1]),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  // Sign restore and result select applied in FIXUP.
  always_comb begin
    q_fix   = q_neg_q ? -quo_q : quo_q;
    r_fix   = r_neg_q ? -rem_q : rem_q;
    fix_res = op_is_rem(op_q) ? r_fix : q_fix;
  end

  // Divider FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= DIV_IDLE;
      op_q     <= MDU_DIV;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over everything, including a simultaneous start.
      state_q <= DIV_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            quo_q   <= a_abs;
            rem_q   <= '0;
            dvsr_q  <= b_abs;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            cnt_q   <= CNT_LOAD;
            if (div_zero || sgn_ovf) begin
              result_q <= fast_res;
              state_q  <= DIV_DONE;
              done_q   <= 1'b1;
            end else begin
              state_q <= DIV_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[XLEN-2:0], step_q};
          if (cnt_q == '0) begin
            state_q <= DIV_FIXUP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIV_FIXUP: begin
          result_q <= fix_res;
          state_q  <= DIV_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Randomized scoreboard bench for mdu_divider against an arithmetic model.
module tb_mdu_divider
  import rv_mdu_pkg::*;
;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  int   busy_lo;
  int   busy_hi;
  logic [W-1:0] last_res;
  exp_t sb[$];

  mdu_divider_if #(.XLEN(W)) bus ();

  mdu_divider #(.XLEN(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // RISC-V M-extension semantics written directly with language arithmetic.
  function automatic logic [W-1:0] model(input mdu_op_t op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic sgn;
    logic want_rem;
    sgn      = (op == MDU_DIV) || (op == MDU_REM);
    want_rem = (op == MDU_REM) || (op == MDU_REMU);
    if (b == 0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return want_rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return want_rem ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
    return want_rem ? a % b : a / b;
  endfunction

  function automatic bit is_fast(input mdu_op_t op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    bit sgn;
    sgn = (op == MDU_DIV) || (op == MDU_REM);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Drive a start in the current cycle; optionally expect its completion.
  task automatic issue(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    exp_t e;
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    if (is_fast(op, a, b)) begin
      e.cyc = cyc + 1;
    end else begin
      e.cyc   = cyc + W + 2;
      busy_lo = cyc + 1;
      busy_hi = cyc + W + 1;
    end
    e.res = model(op, a, b);
    if (push) sb.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < W + 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles at cycle %0d", n, cyc);
    end
  endtask

  task automatic do_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: busy window, and every done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    checks++;
    if (bus.busy !== exp_busy) begin
      errors++;
      $display("FAIL busy cycle %0d: got %b want %b", cyc, bus.busy, exp_busy);
    end
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected cycle %0d: result %h", cyc, bus.result);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.result !== e.res) begin
          errors++;
          $display("FAIL result cycle %0d: got %h want %h", cyc, bus.result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d want %0d", cyc, e.cyc);
        end
        last_res = e.res;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    mdu_op_t      op;
    int           c;

    cyc          = 0;
    checks       = 0;
    errors       = 0;
    busy_lo      = -100;
    busy_hi      = -100;
    last_res     = '0;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.op       = MDU_DIV;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.flush    = 1'b0;

    #12;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_state: busy %b done %b result %h want 0 0 0",
               bus.busy, bus.done, bus.result);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // Directed cases from the plan; consecutive do_op calls start in DONE.
    do_op(MDU_DIVU, 32'd100, 32'd7);
    do_op(MDU_REMU, 32'd100, 32'd7);
    do_op(MDU_DIV,  -32'sd20, 32'd3);
    do_op(MDU_REM,  -32'sd20, 32'd3);
    do_op(MDU_REM,  32'd20, -32'sd3);
    do_op(MDU_DIV,  32'd5, 32'd0);
    do_op(MDU_REMU, 32'd5, 32'd0);
    do_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    do_op(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    do_op(MDU_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
    idle(2);

    // Flush in cycle 10 of a DIVU: no done, result retained.
    c = cyc;
    issue(MDU_DIVU, 32'd1000, 32'd9, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < c + 10) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    busy_hi   = cyc;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: busy %b want 0", bus.busy);
    end
    idle(W + 4);
    checks++;
    if (bus.result !== last_res) begin
      errors++;
      $display("FAIL flush_result: got %h want %h", bus.result, last_res);
    end
    do_op(MDU_DIVU, 32'd9, 32'd3);
    idle(2);

    // Flush together with start: the start is dropped.
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    bus.op       = MDU_DIV;
    bus.dividend = 32'd7;
    bus.divisor  = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    idle(4);

    // Start held high while busy with other operands is ignored.
    issue(MDU_DIV, 32'd12345, -32'sd17, 1'b1);
    for (int i = 0; i < W + 1; i++) begin
      @(posedge clk); #1;
      bus.op       = mdu_op_t'($urandom_range(0, 3));
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();
    idle(2);

    // Reset in cycle 17 of an operation aborts it immediately.
    c = cyc;
    issue(MDU_REMU, 32'd987654, 32'd321, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < c + 17) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    busy_hi = cyc - 1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_abort: busy %b done %b result %h want 0 0 0",
               bus.busy, bus.done, bus.result);
    end
    last_res = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
    do_op(MDU_REMU, 32'd987654, 32'd321);
    idle(1);

    // Randomized mix with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      op = mdu_op_t'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = '0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1, 50);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin
          a = $urandom;
          b = $urandom >> $urandom_range(0, 31);
        end
      endcase
      do_op(op, a, b);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_divider.md
# mdu_divider

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the EX stage beside the multiplier. It produces the `busy`/`done` handshake that the hazard detection unit uses to stall PC and IF/ID. The same handshake drives the IDEX/EXMEM hold signals while a division is in flight. It also handles the RISC-V divide-by-zero and signed-overflow special cases in a 1-cycle fast path.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two ≥ 8.
- `clk`  in  1  single clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend`  in  XLEN  rs1 value, captured on an accepted `start`.
- `divisor`  in  XLEN  rs2 value, captured on an accepted `start`.
- `flush`  in  1  pipeline flush (trap/branch); aborts any operation.
- `result`  out  XLEN  quotient or remainder; registered.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - CALC: `busy`=1, one quotient bit per cycle.
  - FIXUP: `busy`=1, sign correction and op select.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE/DONE + `start` → CALC, or → DONE directly for a special case.
  - IDLE/DONE without `start`: IDLE.
  - CALC → FIXUP after XLEN iterations.
  - FIXUP → DONE.
- Accepted `start`:
  - Latch `op`.
  - Signed ops latch absolute values of the operands plus the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)).
  - Load the iteration counter with XLEN-1.
- CALC step: remainder ← {remainder[XLEN-2:0], quotient MSB}. Trial-subtract the divisor at XLEN+1 bits. If the result is non-negative, keep it and shift in 1; else shift in 0.
- FIXUP: negate the quotient/remainder if their latched sign is set (signed ops only). Register the selected value into `result`.
- Special cases are checked on the latched operands in the cycle of `start` and go straight to DONE:
  - Divisor 0: quotient = all ones; remainder = dividend (unsigned and signed).
  - Signed overflow (dividend = 2^(XLEN-1), divisor = −1): quotient = 2^(XLEN-1), remainder = 0.
- `start` while `busy`=1 is ignored; the operation in progress is unaffected.
- `flush` in any state → IDLE next edge, with `done` suppressed. `result` keeps its previous value. `flush` and `start` in the same cycle: `flush` wins and the start is dropped.
- `result` holds its value until the next DONE. It is never cleared by IDLE.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, counter=0, all latched operands 0. Reset asserted mid-operation aborts immediately with no `done`.
- Normal path, with `start` high in cycle 0:
  - `busy`=1 in cycles 1..XLEN+1 (XLEN CALC cycles plus 1 FIXUP).
  - `done`=1 with `busy`=0 in cycle XLEN+2.
  - Latency is XLEN+2 (34 for XLEN=32).
- Fast path: `done`=1 in cycle 1; `busy` never rises.
- Back-to-back: `start` during the DONE cycle is accepted. `busy` rises in the next cycle with no idle gap.
- `done` is never high for two consecutive cycles unless a fast-path start is accepted during DONE.
- `busy` and `done` are never high simultaneously.

## Structure
- Shared package `rv_mdu_pkg`:
  - `mdu_op_t` (2-bit op encoding above).
  - Divider state enum.
  - `XLEN_DEFAULT`.
  - The multiplier reuses the op type.
- One sub-module, `mdu_div_step`: a combinational single restoring iteration. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder and quotient bit.
- Counter width is $clog2(XLEN).

## Test plan
- DIVU 100/7, `start` at cycle 0 → `busy` in cycles 1..33, `done` in cycle 34, `result`=14. REMU with the same operands → `result`=2.
- DIV −20/3 → `result`=0xFFFFFFFA (−6). REM −20/3 → 0xFFFFFFFE (−2). REM 20/−3 → 2.
- DIV 5/0 → `done` in cycle 1, `result`=0xFFFFFFFF, `busy` never 1. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- `flush` in cycle 10 of a DIVU → IDLE in cycle 11, no `done` pulse, `result` unchanged. Re-`start` 9/3 → 3 after 34 cycles.
- `start` held high during `busy` with different operands → ignored; the first result is correct. A `start` accepted during DONE yields its `done` 34 cycles later.
- Assert `reset_n` low in cycle 17 of an operation → `busy`/`done`/`result` go to 0 immediately; the next request completes normally.
